serial_sub: RTL and testbench



---
 rtl/serial_sub_pkg.sv | 16 +
 rtl/serial_sub_fullsub.sv | 27 ++
 rtl/serial_sub.sv | 90 +++++++++
 tb/tb_serial_sub.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared types for the bit-serial subtractor: FSM state encoding and
// counter sizing helper.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Bit counter needs $clog2(WIDTH) bits, but never fewer than one.
  function automatic int cnt_w(input int width);
    return (width <= 1) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_sub_fullsub.sv
// One-bit subtractor cells: halfsub (a - b) and fullsub_cell, which chains
// two half-subtractors to fold in an incoming borrow.
module halfsub (
  input  logic i_a,
  input  logic i_b,
  output logic o_d,
  output logic o_bor
);
  assign o_d   = i_a ^ i_b;
  assign o_bor = ~i_a & i_b;
endmodule

module fullsub_cell (
  input  logic i_a,
  input  logic i_b,
  input  logic i_bin,
  output logic o_d,
  output logic o_bout
);
  logic w_d1, w_b1, w_b2;

  halfsub u_hs0 (.i_a(i_a),  .i_b(i_b),   .o_d(w_d1), .o_bor(w_b1));
  halfsub u_hs1 (.i_a(w_d1), .i_b(i_bin), .o_d(o_d),  .o_bor(w_b2));

  // At most one stage can borrow, so OR merges them.
  assign o_bout = w_b1 | w_b2;
endmodule

// File: rtl/serial_sub.sv
// Bit-serial WIDTH-bit subtractor: A - B, LSB first, one fullsub_cell and a
// borrow flop, framed by a Start/Busy/Done handshake.
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_diff,
  output logic             o_bor
);
  localparam int            CW   = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a, r_b, r_part;
  logic             r_bin;
  logic             w_d, w_bout;
  logic [WIDTH-1:0] w_part_next;

  fullsub_cell u_cell (
    .i_a   (r_a[0]),
    .i_b   (r_b[0]),
    .i_bin (r_bin),
    .o_d   (w_d),
    .o_bout(w_bout)
  );

  // Writing bit r_cnt directly lands each bit where MSB-shifting would end up.
  always_comb begin
    w_part_next        = r_part;
    w_part_next[r_cnt] = w_d;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_part  <= '0;
      r_bin   <= 1'b0;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
      o_diff  <= '0;
      o_bor   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_a     <= i_a;
            r_b     <= i_b;
            r_bin   <= 1'b0;
            r_cnt   <= '0;
            r_part  <= '0;
            o_busy  <= 1'b1;
            r_state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          r_a    <= r_a >> 1;
          r_b    <= r_b >> 1;
          r_bin  <= w_bout;
          r_part <= w_part_next;
          r_cnt  <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            o_diff  <= w_part_next;
            o_bor   <= w_bout;
            o_done  <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          o_done  <= 1'b0;
          o_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub at WIDTH=8 and WIDTH=1 against an
// arithmetic reference (A - B mod 2^W, borrow = A < B).
module tb_serial_sub;

  logic       clk = 1'b0;
  logic       rst8, start8, rst1, start1;
  logic [7:0] a8, b8, diff8;
  logic       busy8, done8, bor8;
  logic [0:0] a1, b1, diff1;
  logic       busy1, done1, bor1;

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_diff8 = '0;
  logic       exp_bor8  = 1'b0;

  always #5 clk = ~clk;

  serial_sub #(.WIDTH(8)) dut8 (
    .i_clk(clk), .i_rst(rst8), .i_start(start8), .i_a(a8), .i_b(b8),
    .o_busy(busy8), .o_done(done8), .o_diff(diff8), .o_bor(bor8)
  );

  serial_sub #(.WIDTH(1)) dut1 (
    .i_clk(clk), .i_rst(rst1), .i_start(start1), .i_a(a1), .i_b(b1),
    .o_busy(busy1), .o_done(done1), .o_diff(diff1), .o_bor(bor1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One WIDTH=8 operation from IDLE, checking the full latency profile.
  task automatic op8(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] ed;
    logic       eb;
    ed = a - b;
    eb = (a < b);
    @(negedge clk); start8 = 1'b1; a8 = a; b8 = b;
    @(negedge clk); start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    chk("busy_accept", 32'(busy8), 1);
    chk("done_accept", 32'(done8), 0);
    chk("diff_hold_accept", 32'(diff8), 32'(exp_diff8));
    repeat (7) begin
      @(negedge clk);
      chk("done_early", 32'(done8), 0);
      chk("busy_shift", 32'(busy8), 1);
      chk("diff_hold", 32'(diff8), 32'(exp_diff8));
      chk("bor_hold", 32'(bor8), 32'(exp_bor8));
    end
    @(negedge clk);
    chk("done_pulse", 32'(done8), 1);
    chk("busy_done", 32'(busy8), 1);
    chk("diff", 32'(diff8), 32'(ed));
    chk("bor", 32'(bor8), 32'(eb));
    exp_diff8 = ed;
    exp_bor8  = eb;
    @(negedge clk);
    chk("done_end", 32'(done8), 0);
    chk("busy_end", 32'(busy8), 0);
    chk("diff_after", 32'(diff8), 32'(ed));
  endtask

  task automatic op1(input logic a, input logic b);
    logic ed, eb;
    ed = a ^ b;
    eb = ~a & b;
    @(negedge clk); start1 = 1'b1; a1 = a; b1 = b;
    @(negedge clk); start1 = 1'b0; a1 = ~a; b1 = ~b;
    chk("w1_busy_accept", 32'(busy1), 1);
    chk("w1_done_accept", 32'(done1), 0);
    @(negedge clk);
    chk("w1_done", 32'(done1), 1);
    chk("w1_diff", 32'(diff1), 32'(ed));
    chk("w1_bor", 32'(bor1), 32'(eb));
    @(negedge clk);
    chk("w1_done_end", 32'(done1), 0);
    chk("w1_busy_end", 32'(busy1), 0);
  endtask

  initial begin
    logic [7:0] av[30];
    logic [7:0] bv[30];

    rst8 = 1'b1; rst1 = 1'b1; start8 = 1'b0; start1 = 1'b0;
    a8 = '0; b8 = '0; a1 = '0; b1 = '0;
    repeat (2) @(negedge clk);
    rst8 = 1'b0; rst1 = 1'b0;
    chk("rst_busy", 32'(busy8), 0);
    chk("rst_done", 32'(done8), 0);
    chk("rst_diff", 32'(diff8), 0);
    chk("rst_bor", 32'(bor8), 0);
    chk("rst_w1_busy", 32'(busy1), 0);

    // Directed cases
    op8(8'd200, 8'd55);
    op8(8'd55, 8'd200);
    op8(8'd0, 8'd1);
    op8(8'hA5, 8'hA5);
    op8(8'hFF, 8'h00);
    op8(8'h00, 8'hFF);

    // Random cases
    repeat (12) op8(8'($urandom), 8'($urandom));

    // Start held high with operands changing every cycle.
    @(negedge clk);
    start8 = 1'b1; av[0] = 8'($urandom); bv[0] = 8'($urandom);
    a8 = av[0]; b8 = bv[0];
    for (int e = 0; e < 30; e++) begin
      @(negedge clk);
      if ((e % 10) == 8) begin
        exp_diff8 = av[e-8] - bv[e-8];
        exp_bor8  = (av[e-8] < bv[e-8]);
        chk("held_done", 32'(done8), 1);
      end else begin
        chk("held_nodone", 32'(done8), 0);
      end
      chk("held_busy", 32'(busy8), 32'((e % 10) <= 8));
      chk("held_diff", 32'(diff8), 32'(exp_diff8));
      chk("held_bor", 32'(bor8), 32'(exp_bor8));
      if (e < 29) begin
        av[e+1] = 8'($urandom); bv[e+1] = 8'($urandom);
        a8 = av[e+1]; b8 = bv[e+1];
      end else begin
        start8 = 1'b0;
      end
    end

    // Reset three edges into an operation.
    @(negedge clk); start8 = 1'b1; a8 = 8'd77; b8 = 8'd12;
    @(negedge clk); start8 = 1'b0;
    @(negedge clk);
    @(negedge clk); rst8 = 1'b1;
    @(negedge clk); rst8 = 1'b0;
    chk("abort_busy", 32'(busy8), 0);
    chk("abort_done", 32'(done8), 0);
    chk("abort_diff", 32'(diff8), 0);
    chk("abort_bor", 32'(bor8), 0);
    exp_diff8 = '0;
    exp_bor8  = 1'b0;
    repeat (10) begin
      @(negedge clk);
      chk("abort_no_done", 32'(done8), 0);
    end
    op8(8'd9, 8'd3);

    // rst wins over Start on the same edge.
    @(negedge clk); rst8 = 1'b1; start8 = 1'b1; a8 = 8'd5; b8 = 8'd1;
    @(negedge clk); rst8 = 1'b0; start8 = 1'b0;
    chk("rst_prio_busy", 32'(busy8), 0);
    chk("rst_prio_diff", 32'(diff8), 0);
    exp_diff8 = '0;
    exp_bor8  = 1'b0;

    // WIDTH=1 truth table
    op1(1'b0, 1'b0);
    op1(1'b0, 1'b1);
    op1(1'b1, 1'b0);
    op1(1'b1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
